sad_min_tracker: RTL and testbench
==================================

Name: sad_min_tracker

Overview:
- Downstream consumer of the 256-element tree adder.
- For each candidate alignment offset in a SEARCH_X x SEARCH_Y search window, the upstream pipeline presents one window sum per cycle.
- This block takes the magnitude of each sum, tracks the minimum-cost offset in raster order, and presents the winning (x, y, cost) through a valid/ready result handshake at the end of each search.

Parameters:
- SUM_W, 17, width of the signed window sum (tree adder output: input width 9 + 8).
- SEARCH_X, 16, number of x offsets per row; must be ≥ 2.
- SEARCH_Y, 16, number of y offsets (rows); must be ≥ 1.
- COORD_W, 8, width of the offset index outputs; must satisfy 2^COORD_W ≥ max(SEARCH_X, SEARCH_Y).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  single-cycle pulse that begins a new search; honoured only in IDLE.
- sum_valid  in  1  sum_in carries a valid window sum.
- sum_in  in  SUM_W  signed window sum for the current offset.
- sum_ready  out  1  block accepts sum_in this cycle.
- busy  out  1  high in ACCUM and DONE.
- res_valid  out  1  result fields are valid.
- res_ready  in  1  consumer accepts the result.
- res_x  out  COORD_W  x index (0..SEARCH_X-1) of the minimum.
- res_y  out  COORD_W  y index (0..SEARCH_Y-1) of the minimum.
- res_cost  out  SUM_W  unsigned magnitude of the minimum sum.

Behaviour:
- Clocking and reset:
  - One clock.
  - Reset is synchronous and active-low (rst_n sampled on the rising edge of clk).
- Reset values:
  - State = IDLE.
  - sum_ready = 0, res_valid = 0, busy = 0.
  - res_x = 0, res_y = 0, res_cost = all ones.
  - x/y counters = 0.
- Reset mid-search: the search is abandoned, no result is produced, and all registers return to reset values on that edge.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - sum_ready = 0; sum_in is ignored.
  - On start = 1: next state is ACCUM, counters cleared to (0,0), best cost loaded with all ones, res_x/res_y cleared.
- ACCUM:
  - sum_ready = 1 for the whole state.
  - A sample is accepted when sum_valid = 1 and sum_ready = 1. Cycles with sum_valid = 0 stall; counters hold.
  - Magnitude: mag = |sum_in| as an SUM_W-bit unsigned value. The most negative input maps to 2^(SUM_W-1), which fits, so there is no saturation.
  - Update: if mag < best (strict), then best ← mag, res_x ← x count, res_y ← y count. On a tie the earliest offset in raster order is kept.
  - Counter advance per accept:
    - x increments.
    - At x = SEARCH_X-1, x wraps to 0 and y increments.
  - On the accept at (SEARCH_X-1, SEARCH_Y-1):
    - The compare for that sample is applied on the same edge.
    - Next state is DONE and counters reset to 0.
  - start is ignored.
- DONE:
  - res_valid = 1; sum_ready = 0.
  - res_x, res_y and res_cost are stable until the handshake completes.
  - When res_valid = 1 and res_ready = 1, next state is IDLE and res_valid drops the following cycle.
  - start is ignored, including when it coincides with the handshake.
- Latency: res_valid rises on the cycle after the final accept. Total search time is SEARCH_X*SEARCH_Y accepted samples.
- res_cost outputs the best register at all times; it is meaningful only while res_valid = 1.
- busy = (state != IDLE).

Optional Feature:
- Macro: SAD_MIN_SECOND_EN.
- When defined:
  - Adds output port res_cost2 (out, SUM_W bits): the second-lowest magnitude, used for match-confidence ratio checks.
  - Reset value and start-time load: all ones.
  - On accept:
    - If mag < best, then res_cost2 ← best and best ← mag.
    - Else if mag < res_cost2, then res_cost2 ← mag.
    - A tie with best therefore updates res_cost2 to that value.
  - Held stable in DONE like the other result fields.
- When undefined:
  - The port is absent and no second-best logic is built.
  - All other behaviour is identical.

Test Plan:
- Basic minimum (SEARCH_X = SEARCH_Y = 4):
  - Stimulus: reset, start, 16 back-to-back samples = 100 except sample 9 = -7, res_ready = 1.
  - Required response: res_valid one cycle after the 16th accept with res_x = 1, res_y = 2, res_cost = 7; with SAD_MIN_SECOND_EN, res_cost2 = 100.
- Tie and raster order:
  - Stimulus: samples 5 and 12 both = 3, all others 50.
  - Required response: res_x = 1, res_y = 1, res_cost = 3; with the macro, res_cost2 = 3.
- Stalls and backpressure:
  - Stimulus: sum_valid toggled 1/0 every cycle, then res_ready held 0 for 10 cycles in DONE.
  - Required response: exactly 16 accepts counted; result fields are unchanged and res_valid is high throughout the wait; IDLE is entered one cycle after res_ready = 1.
- Most-negative input:
  - Stimulus: all samples = 2^(SUM_W-1)-1 except the last = -2^(SUM_W-1).
  - Required response: the result is sample 0 with res_cost = 65535. The last sample's magnitude 65536 is not smaller and does not wrap.
- Ignored start and reset mid-search:
  - Stimulus: start asserted during ACCUM and during DONE.
  - Required response: no restart and counters unaffected.
  - Stimulus: rst_n = 0 after 7 accepts, then a fresh start with 16 samples.
  - Required response: the result reflects only the new 16 samples; busy and res_valid are 0 the cycle after reset.

Source files
------------

// File: rtl/sad_min_tracker.sv
// sad_min_tracker: scans one search window of signed tree-adder sums, one per
// accepted sample in raster order, and reports the (x, y, cost) of the smallest
// magnitude through a result handshake once the whole window has been seen.
//
// Optional build macro SAD_MIN_SECOND_EN adds res_cost2, the second-lowest
// magnitude seen in the window (for match-confidence ratio checks).
//
// Handshakes: a sum is transferred on a rising edge where sum_valid and
// sum_ready are both high; a result is transferred on a rising edge where
// res_valid and res_ready are both high. Neither ready/valid depends
// combinationally on its partner: sum_ready and res_valid are decoded from the
// registered state only.
module sad_min_tracker #(
  parameter int SUM_W    = 17,
  parameter int SEARCH_X = 16,
  parameter int SEARCH_Y = 16,
  parameter int COORD_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      sum_valid,
  input  logic signed [SUM_W-1:0]   sum_in,
  output logic                      sum_ready,
  output logic                      busy,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [COORD_W-1:0]        res_x,
  output logic [COORD_W-1:0]        res_y,
  output logic [SUM_W-1:0]          res_cost
`ifdef SAD_MIN_SECOND_EN
  ,
  output logic [SUM_W-1:0]          res_cost2
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(SEARCH_X - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(SEARCH_Y - 1);

  logic [1:0]         state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic [COORD_W-1:0] res_x_q, res_x_d;
  logic [COORD_W-1:0] res_y_q, res_y_d;
  logic [SUM_W-1:0]   best_q, best_d;
`ifdef SAD_MIN_SECOND_EN
  logic [SUM_W-1:0]   cost2_q, cost2_d;
`endif

  logic               accept;
  logic [SUM_W-1:0]   mag;

  // The most negative sum negates to 2^(SUM_W-1), which is representable as an
  // unsigned SUM_W-bit value, so a plain two's-complement negate never wraps.
  assign mag    = sum_in[SUM_W-1] ? ($unsigned(~sum_in) + SUM_W'(1)) : $unsigned(sum_in);
  assign accept = (state_q == ST_ACCUM) && sum_valid;

  assign sum_ready = (state_q == ST_ACCUM);
  assign res_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign res_x     = res_x_q;
  assign res_y     = res_y_q;
  assign res_cost  = best_q;
`ifdef SAD_MIN_SECOND_EN
  assign res_cost2 = cost2_q;
`endif

  // Next-state, raster counters and running-minimum update.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    res_x_d = res_x_q;
    res_y_d = res_y_q;
    best_d  = best_q;
`ifdef SAD_MIN_SECOND_EN
    cost2_d = cost2_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ACCUM;
          x_d     = '0;
          y_d     = '0;
          res_x_d = '0;
          res_y_d = '0;
          best_d  = '1;
`ifdef SAD_MIN_SECOND_EN
          cost2_d = '1;
`endif
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          // Strict compare keeps the earliest raster offset on a tie.
          if (mag < best_q) begin
            best_d  = mag;
            res_x_d = x_q;
            res_y_d = y_q;
`ifdef SAD_MIN_SECOND_EN
            cost2_d = best_q;
`endif
          end
`ifdef SAD_MIN_SECOND_EN
          else if (mag < cost2_q) begin
            cost2_d = mag;
          end
`endif
          if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) begin
              y_d     = '0;
              state_d = ST_DONE;
            end else begin
              y_d = y_q + 1'b1;
            end
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      res_x_q <= '0;
      res_y_q <= '0;
      best_q  <= '1;
`ifdef SAD_MIN_SECOND_EN
      cost2_q <= '1;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      res_x_q <= res_x_d;
      res_y_q <= res_y_d;
      best_q  <= best_d;
`ifdef SAD_MIN_SECOND_EN
      cost2_q <= cost2_d;
`endif
    end
  end

endmodule

// File: tb/tb_sad_min_tracker.sv
// Bench for sad_min_tracker on a 4x4 search window. Table vectors carry
// hand-derived results; extra random windows use a small reference model.
module tb_sad_min_tracker;

  localparam int SUM_W = 17;
  localparam int SX    = 4;
  localparam int SY    = 4;
  localparam int CW    = 8;
  localparam int NS    = SX * SY;
  localparam int RES_W = 2 * CW + 2 * SUM_W;

  typedef struct packed {
    logic [CW-1:0]    x;
    logic [CW-1:0]    y;
    logic [SUM_W-1:0] cost;
    logic [SUM_W-1:0] cost2;
  } res_t;

  typedef struct packed {
    logic [NS-1:0][SUM_W-1:0] s;
    logic                     stall;
    logic [3:0]               hold;
    logic                     start_accum;
    logic                     start_done;
    logic                     abort;
    res_t                     exp;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic             clk;
  logic             rst_n;
  logic             start;
  logic             sum_valid;
  logic [SUM_W-1:0] sum_in;
  logic             sum_ready;
  logic             busy;
  logic             res_valid;
  logic             res_ready;
  logic [CW-1:0]    res_x;
  logic [CW-1:0]    res_y;
  logic [SUM_W-1:0] res_cost;
`ifdef SAD_MIN_SECOND_EN
  logic [SUM_W-1:0] res_cost2;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sad_min_tracker #(
    .SUM_W(SUM_W), .SEARCH_X(SX), .SEARCH_Y(SY), .COORD_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .sum_valid(sum_valid), .sum_in(sum_in), .sum_ready(sum_ready),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .res_x(res_x), .res_y(res_y), .res_cost(res_cost)
`ifdef SAD_MIN_SECOND_EN
    , .res_cost2(res_cost2)
`endif
  );

  // ---------------- bookkeeping ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  int accept_cnt = 0;
  logic [RES_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SUM_W-1:0] sv(input int v);
    return v[SUM_W-1:0];
  endfunction

  // Reference: strict running minimum plus second-lowest magnitude.
  function automatic res_t model(input vec_t v);
    res_t r;
    int best, second, idx, s, m;
    best = (1 << SUM_W) - 1;
    second = best;
    idx = 0;
    for (int i = 0; i < NS; i++) begin
      s = int'($signed(v.s[i]));
      m = (s < 0) ? -s : s;
      if (m < best) begin
        second = best;
        best = m;
        idx = i;
      end else if (m < second) begin
        second = m;
      end
    end
    r.x = CW'(idx % SX);
    r.y = CW'(idx / SX);
    r.cost = best[SUM_W-1:0];
    r.cost2 = second[SUM_W-1:0];
    return r;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && sum_valid && sum_ready) accept_cnt++;
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 64'(res_valid), 64'(0));
      end else begin
        res_t e;
        e = exp_q.pop_front();
        check("result_xy_cost", {res_x, res_y, res_cost}, {e.x, e.y, e.cost});
`ifdef SAD_MIN_SECOND_EN
        check("result_cost2", 64'(res_cost2), 64'(e.cost2));
`endif
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_vec(input vec_t v);
    res_ready = (v.hold == 0);
    // sum_in must be ignored while idle
    sum_valid = 1'b1;
    sum_in = '0;
    tick;
    check("idle_sum_ready", 64'(sum_ready), 64'(0));
    sum_valid = 1'b0;
    if (v.abort) begin
      start = 1'b1;
      tick;
      start = 1'b0;
      for (int i = 0; i < 7; i++) begin
        sum_valid = 1'b1;
        sum_in = '0;
        tick;
      end
      sum_valid = 1'b0;
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      check("abort_busy", 64'(busy), 64'(0));
      check("abort_res_valid", 64'(res_valid), 64'(0));
      check("abort_state", {sum_ready, res_x, res_y, res_cost}, {1'b0, 8'd0, 8'd0, 17'h1FFFF});
    end
    exp_q.push_back(v.exp);
    start = 1'b1;
    tick;
    start = 1'b0;
    accept_cnt = 0;
    check("busy_after_start", {busy, sum_ready}, 2'b11);
    for (int i = 0; i < NS; i++) begin
      if (v.stall) begin
        sum_valid = 1'b0;
        sum_in = SUM_W'($urandom);
        tick;
      end
      sum_valid = 1'b1;
      sum_in = v.s[i];
      start = v.start_accum && (i == 5);
      if (i == NS - 1) check("pre_final_res_valid", 64'(res_valid), 64'(0));
      tick;
      start = 1'b0;
    end
    sum_valid = 1'b0;
    check("latency_res_valid", {res_valid, sum_ready}, 2'b10);
    check("accept_count", 64'(accept_cnt), 64'(NS));
    for (int h = 0; h < int'(v.hold); h++) begin
      check("hold_fields", {res_valid, res_x, res_y, res_cost}, {1'b1, v.exp.x, v.exp.y, v.exp.cost});
      start = v.start_done;
      tick;
      start = 1'b0;
    end
    res_ready = 1'b1;
    start = v.start_done;
    tick;
    start = 1'b0;
    check("idle_after_handshake", {busy, res_valid}, 2'b00);
    tick;
    check("still_idle", 64'(busy), 64'(0));
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[6];
  vec_t rv;

  initial begin
    // V0: basic minimum at sample 9 -> (1,2)
    vecs[0] = '0;
    for (int i = 0; i < NS; i++) vecs[0].s[i] = sv(100);
    vecs[0].s[9] = sv(-7);
    vecs[0].exp = '{x: 8'd1, y: 8'd2, cost: 17'd7, cost2: 17'd100};
    // V1: tie at 5 and 12, earliest wins -> (1,1)
    vecs[1] = '0;
    for (int i = 0; i < NS; i++) vecs[1].s[i] = sv(50);
    vecs[1].s[5] = sv(3);
    vecs[1].s[12] = sv(3);
    vecs[1].exp = '{x: 8'd1, y: 8'd1, cost: 17'd3, cost2: 17'd3};
    // V2: stalls, 10-cycle backpressure, start during DONE; min 16 at sample 14
    vecs[2] = '0;
    for (int i = 0; i < NS; i++) vecs[2].s[i] = (i % 2 == 1) ? sv(-(20 + i)) : sv(30 - i);
    vecs[2].stall = 1'b1;
    vecs[2].hold = 4'd10;
    vecs[2].start_done = 1'b1;
    vecs[2].exp = '{x: 8'd2, y: 8'd3, cost: 17'd16, cost2: 17'd18};
    // V3: most-negative last sample does not win or wrap
    vecs[3] = '0;
    for (int i = 0; i < NS; i++) vecs[3].s[i] = sv(65535);
    vecs[3].s[NS-1] = sv(-65536);
    vecs[3].exp = '{x: 8'd0, y: 8'd0, cost: 17'd65535, cost2: 17'd65535};
    // V4: start during ACCUM and at the DONE handshake; min on last sample
    vecs[4] = '0;
    for (int i = 0; i < NS; i++) vecs[4].s[i] = sv(10);
    vecs[4].s[NS-1] = sv(1);
    vecs[4].start_accum = 1'b1;
    vecs[4].start_done = 1'b1;
    vecs[4].exp = '{x: 8'd3, y: 8'd3, cost: 17'd1, cost2: 17'd10};
    // V5: aborted search (zeros) then fresh window, min -2 at sample 6
    vecs[5] = '0;
    for (int i = 0; i < NS; i++) vecs[5].s[i] = sv(i + 20);
    vecs[5].s[6] = sv(-2);
    vecs[5].abort = 1'b1;
    vecs[5].exp = '{x: 8'd2, y: 8'd1, cost: 17'd2, cost2: 17'd20};

    rst_n = 1'b0;
    start = 1'b0;
    sum_valid = 1'b0;
    sum_in = '0;
    res_ready = 1'b0;
    tick;
    tick;
    check("reset_ctrl", {sum_ready, res_valid, busy}, 3'b000);
    check("reset_result", {res_x, res_y, res_cost}, {8'd0, 8'd0, 17'h1FFFF});
    rst_n = 1'b1;
    tick;
    check("post_reset_idle", {sum_ready, res_valid, busy}, 3'b000);

    for (int k = 0; k < 6; k++) run_vec(vecs[k]);

    for (int k = 0; k < 4; k++) begin
      rv = '0;
      for (int i = 0; i < NS; i++)
        rv.s[i] = (k % 2 == 0) ? sv(int'($urandom_range(0, 15)) - 8) : SUM_W'($urandom);
      rv.stall = k[0];
      rv.hold = 4'($urandom_range(0, 3));
      rv.exp = model(rv);
      run_vec(rv);
    end

    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
